// File: rtl/dot8_pkg.sv
// Shared types, default sizes and saturating-add helpers for the dot8_accum block.
// The saturating helpers are only referenced when DOT8_ACCUM_SAT_EN is defined.
package dot8_pkg;

    localparam int DEF_LANES = 8;
    localparam int DEF_DW    = 8;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_LEN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } t_dot8_state;

    localparam logic [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

    // Signed overflow: operands agree in sign and the wrapped sum does not.
    function automatic logic add_ovf(input logic [DEF_ACC_W-1:0] acc,
                                     input logic [DEF_ACC_W-1:0] inc);
        logic [DEF_ACC_W-1:0] sum;
        sum     = acc + inc;
        add_ovf = (acc[DEF_ACC_W-1] == inc[DEF_ACC_W-1]) &&
                  (sum[DEF_ACC_W-1] != acc[DEF_ACC_W-1]);
    endfunction

    function automatic logic [DEF_ACC_W-1:0] sat_add(input logic [DEF_ACC_W-1:0] acc,
                                                      input logic [DEF_ACC_W-1:0] inc);
        if (add_ovf(acc, inc)) begin
            sat_add = acc[DEF_ACC_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_add = acc + inc;
        end
    endfunction

endpackage

// File: rtl/dot8_tree.sv
// Two-stage datapath: registered lane-wise signed products, then a registered
// sign-extended sum of all lanes with a matching valid bit.
module dot8_tree
    import dot8_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [LANES*DW-1:0]   a_i,
    input  logic [LANES*DW-1:0]   b_i,
    output logic [ACC_W-1:0]      sum_o,
    output logic                  vld_o
);

    logic [2*DW-1:0]  prod_d [LANES];
    logic [2*DW-1:0]  prod_q [LANES];
    logic             vld1_q;
    logic [ACC_W-1:0] sum_d;
    logic [ACC_W-1:0] sum_q;
    logic             vld2_q;

    // Lane products, operands widened to 2*DW so the low half is the exact signed product.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic [2*DW-1:0] a_ext;
            logic [2*DW-1:0] b_ext;
            a_ext     = {{DW{a_i[i*DW+DW-1]}}, a_i[i*DW +: DW]};
            b_ext     = {{DW{b_i[i*DW+DW-1]}}, b_i[i*DW +: DW]};
            prod_d[i] = a_ext * b_ext;
        end
    end

    // Stage 1 register: products captured only on accepted pairs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= {(2*DW){1'b0}};
            end
            vld1_q <= 1'b0;
        end else begin
            if (en_i) begin
                for (int i = 0; i < LANES; i++) begin
                    prod_q[i] <= prod_d[i];
                end
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    prod_q[i] <= prod_q[i];
                end
            end
            vld1_q <= en_i;
        end
    end

    // Sign-extended sum of all lane products.
    always_comb begin
        sum_d = {ACC_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + {{(ACC_W-2*DW){prod_q[i][2*DW-1]}}, prod_q[i]};
        end
    end

    // Stage 2 register: lane sum and its valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= {ACC_W{1'b0}};
            vld2_q <= 1'b0;
        end else begin
            if (vld1_q) begin
                sum_q <= sum_d;
            end else begin
                sum_q <= sum_q;
            end
            vld2_q <= vld1_q;
        end
    end

    assign sum_o = sum_q;
    assign vld_o = vld2_q;

endmodule

// File: rtl/dot8_accum.sv
// Packed int8 dot-product accumulator: join handshake on A/B streams, FSM, accumulator, result hold.
// Optional macro DOT8_ACCUM_SAT_EN selects sticky saturating accumulation instead of wrap-around.
module dot8_accum
    import dot8_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  a_valid,
    input  logic [LANES*DW-1:0]   a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [LANES*DW-1:0]   b_data,
    output logic                  b_ready,
    output logic                  busy,
    output logic                  res_valid,
    output logic [ACC_W-1:0]      res_data,
    input  logic                  res_ack
);

    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

    t_dot8_state      state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             drain_q, drain_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             res_valid_q, res_valid_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;

    logic             accept_s;
    logic             start_ok_s;
    logic [ACC_W-1:0] tree_sum_s;
    logic             tree_vld_s;

    // Both words move together, only while the operation still needs pairs.
    assign accept_s   = (state_q == ST_RUN) && a_valid && b_valid && (count_q < len_q);
    assign start_ok_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    dot8_tree #(
        .LANES (LANES),
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_tree (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (accept_s),
        .a_i   (a_data),
        .b_i   (b_data),
        .sum_o (tree_sum_s),
        .vld_o (tree_vld_s)
    );

`ifdef DOT8_ACCUM_SAT_EN
    logic sat_q, sat_d;

    // Sticky clamp: once a rail is hit the accumulator is frozen until the next start.
    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (start_ok_s) begin
            acc_d = {ACC_W{1'b0}};
            sat_d = 1'b0;
        end else if (tree_vld_s && !sat_q) begin
            acc_d = sat_add(acc_q, tree_sum_s);
            sat_d = add_ovf(acc_q, tree_sum_s);
        end else begin
            acc_d = acc_q;
        end
    end

    // Saturation flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`else
    // Wrap-around accumulation of each lane sum as it leaves the tree.
    always_comb begin
        acc_d = acc_q;
        if (start_ok_s) begin
            acc_d = {ACC_W{1'b0}};
        end else if (tree_vld_s) begin
            acc_d = acc_q + tree_sum_s;
        end else begin
            acc_d = acc_q;
        end
    end
`endif

    // Next-state and result logic; DRAIN spans two cycles so the last sum lands before DONE.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        drain_d     = drain_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    len_d       = cfg_len;
                    count_d     = LEN_ZERO;
                    res_valid_d = 1'b0;
                    if (cfg_len == LEN_ZERO) begin
                        state_d     = ST_DONE;
                        res_valid_d = 1'b1;
                        res_data_d  = {ACC_W{1'b0}};
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if ((state_q == ST_DONE) && res_ack) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    count_d = count_q + LEN_ONE;
                    if (count_d == len_q) begin
                        state_d = ST_DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                    res_data_d  = acc_d;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= LEN_ZERO;
            count_q     <= LEN_ZERO;
            drain_q     <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            res_valid_q <= 1'b0;
            res_data_q  <= {ACC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            drain_q     <= drain_d;
            acc_q       <= acc_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign a_ready   = accept_s;
    assign b_ready   = accept_s;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_dot8_accum.sv
// Directed/randomised bench for dot8_accum with an arithmetic reference model.
module tb_dot8_accum;

    localparam longint SAT_MAX = 64'sd8388607;
    localparam longint SAT_MIN = -64'sd8388608;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_len;
    logic        a_valid;
    logic [63:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [63:0] b_data;
    logic        b_ready;
    logic        busy;
    logic        res_valid;
    logic [23:0] res_data;
    logic        res_ack;

    int checks = 0;
    int errors = 0;

    dot8_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .busy      (busy),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ack   (res_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Exact signed dot product of one word pair.
    function automatic longint dotw(input logic [63:0] a, input logic [63:0] b);
        longint s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            s += longint'($signed(a[8*i +: 8])) * longint'($signed(b[8*i +: 8]));
        end
        return s;
    endfunction

    // pat: 0 both valid, 1 A toggles / B always valid, 2 random valids.
    task automatic run_op(input int len, input int pat, input logic [63:0] fa, input logic [63:0] fb,
                          input bit rnd, input bit poke, input bit ack, input string tag,
                          output logic [23:0] obs);
        logic [63:0] aw[$];
        logic [63:0] bw[$];
        longint      acc;
        bit          railed;
        logic [23:0] exp;
        int          acc_cnt;
        int          cyc;
        int          lat;
        int          bad_hs;

        acc    = 0;
        railed = 1'b0;
        for (int i = 0; i < len; i++) begin
            aw.push_back(rnd ? {$urandom, $urandom} : fa);
            bw.push_back(rnd ? {$urandom, $urandom} : fb);
`ifdef DOT8_ACCUM_SAT_EN
            if (!railed) begin
                acc += dotw(aw[i], bw[i]);
                if (acc > SAT_MAX) begin
                    acc = SAT_MAX;
                    railed = 1'b1;
                end else if (acc < SAT_MIN) begin
                    acc = SAT_MIN;
                    railed = 1'b1;
                end
            end
`else
            acc += dotw(aw[i], bw[i]);
`endif
        end
        exp = acc[23:0];

        start   = 1'b1;
        cfg_len = len[7:0];
        step();
        start   = 1'b0;
        cfg_len = 8'd0;

        if (len == 0) begin
            check({tag, "_zero_valid"}, {63'd0, res_valid}, 64'd1);
            check({tag, "_zero_busy"}, {63'd0, busy}, 64'd0);
            check({tag, "_zero_data"}, {40'd0, res_data}, 64'd0);
        end else begin
            check({tag, "_dropped"}, {63'd0, res_valid}, 64'd0);
            check({tag, "_busy_run"}, {63'd0, busy}, 64'd1);
            acc_cnt = 0;
            cyc     = 0;
            bad_hs  = 0;
            while (acc_cnt < len && cyc < 2000) begin
                case (pat)
                    1: begin a_valid = (cyc % 2 == 0); b_valid = 1'b1; end
                    2: begin a_valid = $urandom_range(0, 1) == 1; b_valid = $urandom_range(0, 1) == 1; end
                    default: begin a_valid = 1'b1; b_valid = 1'b1; end
                endcase
                a_data = aw[acc_cnt];
                b_data = bw[acc_cnt];
                if (poke && cyc == 1) begin
                    start   = 1'b1;
                    cfg_len = 8'd200;
                end else begin
                    start   = 1'b0;
                    cfg_len = 8'd0;
                end
                #1;
                if ((a_ready !== b_ready) || (a_ready && !(a_valid && b_valid))) bad_hs++;
                if (a_ready === 1'b1) acc_cnt++;
                step();
                cyc++;
            end
            start   = 1'b0;
            a_valid = 1'b0;
            b_valid = 1'b0;
            check({tag, "_accepts"}, 64'(acc_cnt), 64'(len));
            check({tag, "_handshake"}, 64'(bad_hs), 64'd0);
            check({tag, "_busy_drain"}, {63'd0, busy}, 64'd1);
            lat = 1;
            while (res_valid !== 1'b1 && lat < 20) begin
                step();
                lat++;
            end
            check({tag, "_latency"}, 64'(lat), 64'd3);
            check({tag, "_data"}, {40'd0, res_data}, {40'd0, exp});
            check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        end
        obs = res_data;

        if (ack) begin
            res_ack = 1'b1;
            step();
            res_ack = 1'b0;
            check({tag, "_ack_valid"}, {63'd0, res_valid}, 64'd0);
            check({tag, "_ack_hold"}, {40'd0, res_data}, {40'd0, exp});
        end
    endtask

    initial begin
        logic [23:0] r;
        rst_n   = 1'b0;
        start   = 1'b0;
        cfg_len = 8'd0;
        a_valid = 1'b0;
        a_data  = 64'd0;
        b_valid = 1'b0;
        b_data  = 64'd0;
        res_ack = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_res_data", {40'd0, res_data}, 64'd0);
        check("rst_ready", {62'd0, a_ready, b_ready}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_busy", {63'd0, busy}, 64'd0);
        check("post_rst_valid", {63'd0, res_valid}, 64'd0);

        run_op(1, 0, 64'h0101010101010101, 64'h0202020202020202, 1'b0, 1'b0, 1'b1, "ones", r);
        check("ones_const", {40'd0, r}, 64'd16);

        run_op(1, 0, 64'hFFFFFFFFFFFFFFFF, 64'h7F7F7F7F7F7F7F7F, 1'b0, 1'b0, 1'b1, "neg", r);
        check("neg_const", {40'd0, r}, 64'hFFFC08);

        run_op(4, 1, 64'd0, 64'd0, 1'b1, 1'b1, 1'b1, "toggle", r);

        run_op(64, 0, 64'h8080808080808080, 64'h8080808080808080, 1'b0, 1'b0, 1'b1, "ovf_pos", r);
`ifdef DOT8_ACCUM_SAT_EN
        check("ovf_pos_const", {40'd0, r}, 64'h7FFFFF);
`else
        check("ovf_pos_const", {40'd0, r}, 64'h800000);
`endif

        run_op(65, 0, 64'h8080808080808080, 64'h7F7F7F7F7F7F7F7F, 1'b0, 1'b0, 1'b1, "ovf_neg", r);

        // Result left unacknowledged so the next start comes from DONE.
        run_op(int'($urandom_range(1, 12)), 2, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, "rand0", r);
        for (int k = 1; k < 5; k++) begin
            run_op(int'($urandom_range(1, 12)), k % 3, 64'd0, 64'd0, 1'b1, 1'b0, 1'b1,
                   $sformatf("rand%0d", k), r);
        end

        run_op(0, 0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, "len0", r);

        // Reset in the middle of a 5-pair run, after two pairs were accepted.
        start   = 1'b1;
        cfg_len = 8'd5;
        step();
        start   = 1'b0;
        cfg_len = 8'd0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = {$urandom, $urandom};
        b_data  = {$urandom, $urandom};
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {62'd0, a_ready, b_ready}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_valid", {63'd0, res_valid}, 64'd0);
        check("midrst_data", {40'd0, res_data}, 64'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("midrst_post_busy", {63'd0, busy}, 64'd0);
        run_op(1, 0, 64'h0000000000000003, 64'h00000000000000FE, 1'b0, 1'b0, 1'b1, "after_rst", r);
        check("after_rst_const", {40'd0, r}, 64'hFFFFFA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
